// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC hit readout path.
//   - Encoder field widths (TOA, TOT, Cal).
//   - Bit positions inside the packed readout word
//     {BCID, CalErr, TOTErr, TOAErr, TOT, TOA, Cal}.
//   - pack_hit(): assembles the low 32 bits of that word.
package tdc_pkg;

  localparam int TOA_W      = 10;
  localparam int TOT_W      = 9;
  localparam int CAL_W      = 10;

  localparam int CAL_LSB    = 0;
  localparam int TOA_LSB    = CAL_LSB + CAL_W;   // 10
  localparam int TOT_LSB    = TOA_LSB + TOA_W;   // 20
  localparam int TOAERR_BIT = TOT_LSB + TOT_W;   // 29
  localparam int TOTERR_BIT = TOAERR_BIT + 1;    // 30
  localparam int CALERR_BIT = TOTERR_BIT + 1;    // 31
  localparam int BCID_LSB   = CALERR_BIT + 1;    // 32
  localparam int HIT_W      = BCID_LSB;          // word width without the BCID

  function automatic logic [HIT_W-1:0] pack_hit(
    input logic [TOA_W-1:0] toa,
    input logic [TOT_W-1:0] tot,
    input logic [CAL_W-1:0] cal,
    input logic             toa_err,
    input logic             tot_err,
    input logic             cal_err
  );
    return {cal_err, tot_err, toa_err, tot, toa, cal};
  endfunction

endpackage

// File: rtl/tdc_hit_readout_if.sv
// Valid/ready readout stream carrying packed hit words downstream.
//   hitData  : packed hit word (WIDTH bits), driven by master
//   hitValid : hitData holds a word, driven by master
//   hitReady : downstream accepts the word this cycle, driven by slave
interface tdc_hit_readout_if #(
  parameter int WIDTH = 44
);
  logic [WIDTH-1:0] hitData;
  logic             hitValid;
  logic             hitReady;

  modport master (output hitData, output hitValid, input  hitReady);
  modport slave  (input  hitData, input  hitValid, output hitReady);
endinterface

// File: rtl/tdc_sync_fifo.sv
// Show-ahead synchronous FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (flushes pointers/count)
//   i_push     : write i_data; taken when not full, or when full with a pop
//   i_data     : write data
//   i_pop      : consume head; ignored when empty
//   o_data     : head word, 0 while empty (registered state only)
//   o_full     : occupancy == DEPTH
//   o_empty    : occupancy == 0
//   o_count    : occupancy 0..DEPTH
module tdc_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 44,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  assign w_pop  = i_pop & ~o_empty;
  // When full, a same-cycle pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the write can proceed.
  assign w_push = i_push & (~o_full | w_pop);

  // Gate the head so the stale array content never leaks out when empty.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tdc_hit_readout.sv
// Readout-side capture of TDC encoder hits.
// Captures one word per rising edge of hitFlag, tags it with the current
// bunch-crossing ID, optionally discards words carrying error flags, and
// queues them in a show-ahead FIFO that drains over a valid/ready stream.
//   clk40, resetn            : 40 MHz clock, asynchronous active-low reset
//   hitFlag                  : encoder hit level
//   TOA/TOT/Cal_codeReg      : encoded fields
//   TOA/TOT/CalerrorFlagReg  : encoder error flags
//   bcReset                  : synchronous BCID clear
//   dropErrors               : discard words with any error flag
//   rd (master)              : hitData / hitValid / hitReady stream
//   fifoCount                : FIFO occupancy
//   overflowCnt, clrOverflow : saturating dropped-word counter and its clear
module tdc_hit_readout
  import tdc_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int BCID_W = 12,
  localparam int WORD_W = BCID_W + HIT_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk40,
  input  logic               resetn,
  input  logic               hitFlag,
  input  logic [TOA_W-1:0]   TOA_codeReg,
  input  logic [TOT_W-1:0]   TOT_codeReg,
  input  logic [CAL_W-1:0]   Cal_codeReg,
  input  logic               TOAerrorFlagReg,
  input  logic               TOTerrorFlagReg,
  input  logic               CalerrorFlagReg,
  input  logic               bcReset,
  input  logic               dropErrors,
  input  logic               clrOverflow,
  output logic [CNT_W-1:0]   fifoCount,
  output logic [7:0]         overflowCnt,
  tdc_hit_readout_if.master  rd
);

  logic [BCID_W-1:0] r_bcid;
  logic              r_hitPrev;
  logic [7:0]        r_ovf;

  logic              w_capture;
  logic              w_anyErr;
  logic              w_keep;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_head;

  assign w_capture = hitFlag & ~r_hitPrev;
  assign w_anyErr  = TOAerrorFlagReg | TOTerrorFlagReg | CalerrorFlagReg;
  // Filtered words vanish silently; they are not overflow losses.
  assign w_keep    = w_capture & ~(dropErrors & w_anyErr);
  assign w_pop     = rd.hitValid & rd.hitReady;
  assign w_drop    = w_keep & w_full & ~w_pop;

  // Tag with the BCID held during the capture cycle (pre-increment).
  assign w_word = {r_bcid,
                   pack_hit(TOA_codeReg, TOT_codeReg, Cal_codeReg,
                            TOAerrorFlagReg, TOTerrorFlagReg, CalerrorFlagReg)};

  tdc_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk40),
    .rst_n   (resetn),
    .i_push  (w_keep),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifoCount)
  );

  assign rd.hitData  = w_head;
  assign rd.hitValid = ~w_empty;
  assign overflowCnt = r_ovf;

  always_ff @(posedge clk40 or negedge resetn) begin
    if (!resetn) begin
      r_bcid    <= '0;
      r_hitPrev <= 1'b0;
      r_ovf     <= '0;
    end else begin
      r_bcid    <= bcReset ? '0 : r_bcid + 1'b1;
      r_hitPrev <= hitFlag;
      if (clrOverflow)                 r_ovf <= '0;
      else if (w_drop && r_ovf != '1) r_ovf <= r_ovf + 1'b1;
    end
  end

endmodule

// File: tb/tb_tdc_hit_readout.sv
module tb_tdc_hit_readout;
  import tdc_pkg::*;

  logic        clk40 = 1'b0;
  logic        resetn = 1'b0;
  logic        hitFlag = 1'b0;
  logic [9:0]  TOA_codeReg = '0;
  logic [8:0]  TOT_codeReg = '0;
  logic [9:0]  Cal_codeReg = '0;
  logic        TOAerrorFlagReg = 1'b0;
  logic        TOTerrorFlagReg = 1'b0;
  logic        CalerrorFlagReg = 1'b0;
  logic        bcReset = 1'b0;
  logic        dropErrors = 1'b0;
  logic        clrOverflow = 1'b0;
  logic [3:0]  fifoCount;
  logic [7:0]  overflowCnt;

  int nvec = 0;
  int nerr = 0;

  tdc_hit_readout_if #(.WIDTH(44)) rd_if ();

  tdc_hit_readout #(.DEPTH(8), .BCID_W(12)) dut (
    .clk40           (clk40),
    .resetn          (resetn),
    .hitFlag         (hitFlag),
    .TOA_codeReg     (TOA_codeReg),
    .TOT_codeReg     (TOT_codeReg),
    .Cal_codeReg     (Cal_codeReg),
    .TOAerrorFlagReg (TOAerrorFlagReg),
    .TOTerrorFlagReg (TOTerrorFlagReg),
    .CalerrorFlagReg (CalerrorFlagReg),
    .bcReset         (bcReset),
    .dropErrors      (dropErrors),
    .clrOverflow     (clrOverflow),
    .fifoCount       (fifoCount),
    .overflowCnt     (overflowCnt),
    .rd              (rd_if.master)
  );

  always #5 clk40 = ~clk40;

  // Reference bunch-crossing count, used to predict the tag on each hit.
  logic [11:0] tb_bc;
  always @(posedge clk40 or negedge resetn) begin
    if (!resetn)      tb_bc <= '0;
    else if (bcReset) tb_bc <= '0;
    else              tb_bc <= tb_bc + 12'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk40);
    #1;
  endtask

  task automatic set_fields(input [9:0] toa, input [8:0] tot, input [9:0] cal, input [2:0] err);
    TOA_codeReg = toa; TOT_codeReg = tot; Cal_codeReg = cal;
    {CalerrorFlagReg, TOTerrorFlagReg, TOAerrorFlagReg} = err;
  endtask

  // One-cycle hit pulse followed by a low cycle; returns the word it should produce.
  task automatic hit(input [9:0] toa, input [8:0] tot, input [9:0] cal, input [2:0] err,
                     output logic [43:0] w);
    set_fields(toa, tot, cal, err);
    w = {tb_bc, err, tot, toa, cal};
    hitFlag = 1'b1;
    step();
    hitFlag = 1'b0;
    step();
  endtask

  task automatic wait_bc(input [11:0] target);
    int n = 0;
    while (tb_bc != target && n < 5000) begin step(); n++; end
    if (tb_bc != target) chk("wait_bc timeout", 64'(tb_bc), 64'(target));
  endtask

  logic [43:0] w;
  logic [43:0] wnew;
  logic [43:0] exq [10];

  initial begin
    rd_if.hitReady = 1'b0;

    // ---- reset state ----
    #12;
    chk("rst hitValid",    64'(rd_if.hitValid), 64'd0);
    chk("rst hitData",     64'(rd_if.hitData),  64'd0);
    chk("rst fifoCount",   64'(fifoCount),      64'd0);
    chk("rst overflowCnt", 64'(overflowCnt),    64'd0);
    step();
    resetn = 1'b1;

    // ---- single hit, BCID 37, held high 3 cycles ----
    wait_bc(12'd37);
    set_fields(10'h155, 9'h0AA, 10'h0C8, 3'b000);
    hitFlag = 1'b1;
    step();
    chk("single hitValid", 64'(rd_if.hitValid), 64'd1);
    chk("single hitData",  64'(rd_if.hitData),
        64'({12'd37, 3'b000, 9'h0AA, 10'h155, 10'h0C8}));
    step();
    step();
    hitFlag = 1'b0;
    chk("single count held", 64'(fifoCount), 64'd1);
    rd_if.hitReady = 1'b1;
    step();
    chk("single drained valid", 64'(rd_if.hitValid), 64'd0);
    chk("single drained count", 64'(fifoCount), 64'd0);
    rd_if.hitReady = 1'b0;

    // ---- backpressure and overflow: 10 hits into depth 8 ----
    for (int i = 0; i < 10; i++) begin
      hit(10'(i + 1), 9'(3 * i + 5), 10'(100 + i), 3'b000, w);
      exq[i] = w;
    end
    chk("ovf fifoCount",   64'(fifoCount),   64'd8);
    chk("ovf overflowCnt", 64'(overflowCnt), 64'd2);
    rd_if.hitReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain valid", 64'(rd_if.hitValid), 64'd1);
      chk("drain order", 64'(rd_if.hitData),  64'(exq[i]));
      step();
    end
    chk("drain empty", 64'(rd_if.hitValid), 64'd0);
    rd_if.hitReady = 1'b0;

    // ---- full with simultaneous push and pop ----
    for (int i = 0; i < 8; i++) hit(10'(200 + i), 9'd1, 10'd2, 3'b000, w);
    chk("fill count", 64'(fifoCount), 64'd8);
    set_fields(10'h3FF, 9'h1FF, 10'h3FF, 3'b000);
    wnew = {tb_bc, 3'b000, 9'h1FF, 10'h3FF, 10'h3FF};
    hitFlag = 1'b1;
    rd_if.hitReady = 1'b1;
    step();
    hitFlag = 1'b0;
    rd_if.hitReady = 1'b0;
    chk("pushpop count", 64'(fifoCount),   64'd8);
    chk("pushpop ovf",   64'(overflowCnt), 64'd2);
    step();

    // ---- saturation at 255, then clear beating a same-cycle drop ----
    for (int i = 0; i < 260; i++) hit(10'd7, 9'd7, 10'd7, 3'b000, w);
    chk("ovf saturate", 64'(overflowCnt), 64'd255);
    set_fields(10'd9, 9'd9, 10'd9, 3'b000);
    hitFlag = 1'b1;
    clrOverflow = 1'b1;
    step();
    hitFlag = 1'b0;
    clrOverflow = 1'b0;
    chk("clr priority", 64'(overflowCnt), 64'd0);
    chk("clr count",    64'(fifoCount),   64'd8);
    rd_if.hitReady = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("pushpop word tail", 64'(rd_if.hitData), 64'(wnew));
    step();
    chk("pushpop empty", 64'(rd_if.hitValid), 64'd0);
    rd_if.hitReady = 1'b0;

    // ---- error filter ----
    dropErrors = 1'b1;
    hit(10'h011, 9'h022, 10'h033, 3'b001, w);
    chk("filter count", 64'(fifoCount),   64'd0);
    chk("filter ovf",   64'(overflowCnt), 64'd0);
    dropErrors = 1'b0;
    hit(10'h011, 9'h022, 10'h033, 3'b001, w);
    chk("nofilter count", 64'(fifoCount), 64'd1);
    chk("nofilter bit29", 64'(rd_if.hitData[29]), 64'd1);
    chk("nofilter word",  64'(rd_if.hitData), 64'(w));
    set_fields('0, '0, '0, 3'b000);
    rd_if.hitReady = 1'b1;
    step();
    rd_if.hitReady = 1'b0;

    // ---- bcReset: same-cycle hit keeps old BCID ----
    wait_bc(12'd100);
    set_fields(10'd1, 9'd2, 10'd3, 3'b000);
    hitFlag = 1'b1;
    bcReset = 1'b1;
    step();
    hitFlag = 1'b0;
    bcReset = 1'b0;
    chk("bcReset same-cycle tag", 64'(rd_if.hitData[43:32]), 64'd100);
    rd_if.hitReady = 1'b1;
    step();
    rd_if.hitReady = 1'b0;
    // bcReset alone, hit on the following cycle is tagged 0
    bcReset = 1'b1;
    step();
    bcReset = 1'b0;
    hitFlag = 1'b1;
    step();
    hitFlag = 1'b0;
    chk("bcReset next tag", 64'(rd_if.hitData[43:32]), 64'd0);
    rd_if.hitReady = 1'b1;
    step();
    rd_if.hitReady = 1'b0;

    // ---- wrap: hit 4096 cycles after reset release is tagged 0 ----
    resetn = 1'b0;
    #1;
    step();
    resetn = 1'b1;
    for (int i = 0; i < 4096; i++) step();
    hitFlag = 1'b1;
    step();
    hitFlag = 1'b0;
    chk("wrap tag", 64'(rd_if.hitData[43:32]), 64'd0);
    rd_if.hitReady = 1'b1;
    step();
    rd_if.hitReady = 1'b0;

    // ---- asynchronous reset with 5 words queued ----
    for (int i = 0; i < 5; i++) hit(10'(50 + i), 9'd4, 10'd5, 3'b000, w);
    chk("pre-reset count", 64'(fifoCount), 64'd5);
    #2;
    resetn = 1'b0;
    #1;
    chk("async hitValid",    64'(rd_if.hitValid), 64'd0);
    chk("async fifoCount",   64'(fifoCount),      64'd0);
    chk("async overflowCnt", 64'(overflowCnt),    64'd0);
    step();
    resetn = 1'b1;
    step();
    hit(10'h2AB, 9'h0CD, 10'h1EF, 3'b000, w);
    chk("post-reset count", 64'(fifoCount), 64'd1);
    chk("post-reset word",  64'(rd_if.hitData), 64'(w));
    rd_if.hitReady = 1'b1;
    step();
    chk("post-reset empty", 64'(rd_if.hitValid), 64'd0);
    step();
    chk("post-reset stays empty", 64'(rd_if.hitValid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
